// File: rtl/ysyx_23060236_icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
// The fill FSM and the line geometry are defined here so every file agrees on them.
package ysyx_23060236_icache_pkg;

  localparam int ICACHE_ADDR_W  = 25;
  localparam int ICACHE_INDEX_W = 4;
  localparam int OFFSET_W       = 5;
  localparam int WORD_SEL_W     = 3;
  localparam int WORDS_PER_LINE = 8;
  localparam int FSM_STATE_W    = 2;

  typedef enum logic [FSM_STATE_W-1:0] {
    FSM_IDLE      = 2'd0,
    FSM_FILL      = 2'd1,
    FSM_FILL_DROP = 2'd2
  } fill_state_e;

  function automatic logic is_last_word(input logic [WORD_SEL_W-1:0] word);
    return word == WORD_SEL_W'(WORDS_PER_LINE - 1);
  endfunction

  function automatic logic is_first_word(input logic [WORD_SEL_W-1:0] word);
    return word == '0;
  endfunction

endpackage

// File: rtl/ysyx_23060236_icache_reg.sv
// Generic register with synchronous active-high reset and write enable.
// Used to hold the refill FSM state of the instruction cache.
module ysyx_23060236_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060236_icache.sv
// Direct-mapped instruction cache, 32-byte lines, zero-latency read port and a
// word-at-a-time refill port; a line becomes valid only after its last word lands.
module ysyx_23060236_icache
  import ysyx_23060236_icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int ADDR_W  = ICACHE_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_araddr,
  output logic [31:0]       icache_rdata,
  output logic              icache_hit,
  input  logic [ADDR_W-1:0] icache_awaddr,
  input  logic [31:0]       icache_wdata,
  input  logic              icache_wvalid,
  input  logic              fence_i,
  output logic              fill_busy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;

  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [INDEX_W-1:0] fill_idx_q;

  logic [INDEX_W-1:0]    rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic [WORD_SEL_W-1:0] rd_word, wr_word;

  logic [FSM_STATE_W-1:0] state_raw;
  fill_state_e            state_q, state_d;
  logic                   fill_start, fill_done;
  logic                   unused_addr_bits;

  assign rd_idx  = icache_araddr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign rd_tag  = icache_araddr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign rd_word = icache_araddr[OFFSET_W-1:2];
  assign wr_idx  = icache_awaddr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign wr_tag  = icache_awaddr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign wr_word = icache_awaddr[OFFSET_W-1:2];

  assign unused_addr_bits = &{1'b0, icache_araddr[1:0], icache_awaddr[1:0]};

  // Read stage: purely combinational against the pre-edge arrays
  assign icache_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign icache_rdata = icache_hit ? data_q[rd_idx][rd_word] : 32'd0;

  assign state_q   = fill_state_e'(state_raw);
  assign fill_busy = (state_q != FSM_IDLE);

  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        if (icache_wvalid && is_first_word(wr_word)) begin
          fill_start = 1'b1;
          state_d    = fence_i ? FSM_FILL_DROP : FSM_FILL;
        end
      end
      FSM_FILL: begin
        if (icache_wvalid && is_last_word(wr_word)) begin
          fill_done = !fence_i;
          state_d   = FSM_IDLE;
        end else if (fence_i) begin
          state_d = FSM_FILL_DROP;
        end
      end
      FSM_FILL_DROP: begin
        if (icache_wvalid && is_last_word(wr_word)) begin
          state_d = FSM_IDLE;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  ysyx_23060236_Reg #(
    .WIDTH    (FSM_STATE_W),
    .RESET_VAL(FSM_IDLE)
  ) u_state_reg (
    .clock(clock),
    .reset(reset),
    .din  (state_d),
    .dout (state_raw),
    .wen  (1'b1)
  );

  // Write stage: data lands regardless of FSM state
  always_ff @(posedge clock) begin
    if (icache_wvalid) begin
      data_q[wr_idx][wr_word] <= icache_wdata;
    end
  end

  // The fill index is latched so the final valid set survives any awaddr drift
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (fill_start) begin
        tag_q[wr_idx]   <= wr_tag;
        valid_q[wr_idx] <= 1'b0;
        fill_idx_q      <= wr_idx;
      end
      if (fill_done) begin
        valid_q[fill_idx_q] <= 1'b1;
      end
      if (fence_i) begin
        valid_q <= '0;
      end
    end
  end

endmodule
